// File: rtl/input_and_mar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_and_mar_pkg
// Description : Shared constants for the SAP-2-mini input selector and MAR.
//               ADDR_WIDTH is the CPU-wide address width. It is used as the
//               default WIDTH of the MAR and of its bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package input_and_mar_pkg;

  // CPU-wide address width (RAM address lines and W-bus address field).
  localparam int ADDR_WIDTH = 8;

endpackage : input_and_mar_pkg
`default_nettype wire

// File: rtl/input_and_mar_if.sv
`default_nettype none
// ============================================================================
// Module      : input_and_mar_if
// Description : Load/select/address bundle between the control side and the
//               MAR.
//                 lm   - load-MAR enable, active high
//                 prog - source select: 1 = switches (in), 0 = W-bus (a)
//                 a    - address from the W-bus (run mode)
//                 in   - address from the front-panel switches (program mode)
//                 out  - registered MAR contents, to the RAM address inputs
//               master : drives lm/prog/a/in and observes out
//               slave  : the MAR itself; it samples lm/prog/a/in and drives out
// Revision    : 1.0 - initial release
// ============================================================================
interface input_and_mar_if
  import input_and_mar_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH
);

  logic             lm;
  logic             prog;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  modport master (
    output lm,
    output prog,
    output a,
    output in,
    input  out
  );

  modport slave (
    input  lm,
    input  prog,
    input  a,
    input  in,
    output out
  );

endinterface : input_and_mar_if
`default_nettype wire

// File: rtl/input_and_mar.sv
`default_nettype none
// ============================================================================
// Module      : input_and_mar
// Description : Memory Address Register with program/run input selector for
//               the SAP-2-mini CPU. In run mode the MAR loads from the W-bus
//               (a). In program mode it loads from the front-panel switches
//               (in). The register output drives the RAM address lines.
// Ports       : clk  - system clock, all state changes on its rising edge
//               clr  - synchronous active-high reset. It has priority over a
//                      load.
//               bus  - input_and_mar_if.slave (lm, prog, a, in, out)
// Revision    : 1.0 - initial release
// ============================================================================
module input_and_mar
  import input_and_mar_pkg::*;
#(
  parameter int               WIDTH       = ADDR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire                 clk,
  input  wire                 clr,
  input_and_mar_if.slave      bus
);

  logic [WIDTH-1:0] mar;

  // The source mux sits in front of the register. out therefore has no
  // combinational path from any input. While lm is low, prog, a and in are
  // ignored.
  always_ff @(posedge clk) begin
    if (clr) begin
      mar <= RESET_VALUE;
    end else if (bus.lm) begin
      mar <= bus.prog ? bus.in : bus.a;
    end
  end

  assign bus.out = mar;

endmodule : input_and_mar
`default_nettype wire

// File: tb/tb_input_and_mar.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_and_mar
// Description : Self-checking bench for input_and_mar. A behavioural model of
//               the MAR is checked against out on every falling edge once the
//               first clr has been applied. Directed steps also pin out and
//               the model to hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_and_mar;

  localparam int W = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  input_and_mar_if #(.WIDTH(W)) bus ();

  input_and_mar #(
    .WIDTH       (W),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: what the MAR must hold after each edge.
  logic [W-1:0] model_mar;
  bit           model_valid = 1'b0;

  function automatic logic [W-1:0] expected_next(
    input logic [W-1:0] cur,
    input logic         c,
    input logic         l,
    input logic         p,
    input logic [W-1:0] av,
    input logic [W-1:0] iv
  );
    logic [W-1:0] r;
    r = cur;
    if (c)      r = 8'h00;   // reset wins over everything
    else if (l) begin
      if (p) r = iv;         // program mode: switches
      else   r = av;         // run mode: W-bus
    end
    return r;
  endfunction

  always @(posedge clk) begin
    model_mar <= expected_next(model_mar, clr, bus.lm, bus.prog, bus.a, bus.in);
    if (clr) model_valid <= 1'b1;
  end

  // Continuous comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (bus.out !== model_mar) begin
        failures++;
        $display("FAIL model_cmp t=%0t out=%h expected=%h", $time, bus.out, model_mar);
      end
    end
  end

  // Apply one set of inputs mid-cycle, then let one rising edge pass.
  task automatic drive(input logic c, input logic l, input logic p,
                       input logic [W-1:0] av, input logic [W-1:0] iv);
    @(negedge clk);
    clr      = c;
    bus.lm   = l;
    bus.prog = p;
    bus.a    = av;
    bus.in   = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [W-1:0] exp);
    checks++;
    if (bus.out !== exp) begin
      failures++;
      $display("FAIL %s out=%h expected=%h", name, bus.out, exp);
    end
    checks++;
    if (model_mar !== exp) begin
      failures++;
      $display("FAIL %s_model model=%h expected=%h", name, model_mar, exp);
    end
  endtask

  initial begin
    bus.lm   = 1'b0;
    bus.prog = 1'b0;
    bus.a    = '0;
    bus.in   = '0;
    model_mar = '0;
    repeat (2) @(posedge clk);

    // Reset with a load also requested: reset must win.
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h55);
    check_lit("reset", 8'h00);

    // Hold: lm low, prog toggling, a and in changing every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i[0], 8'(8'h13 + i * 17), 8'(8'hC7 - i * 29));
      check_lit("hold", 8'h00);
    end

    // Run-mode load. out keeps its old value until the edge.
    @(negedge clk);
    clr = 1'b0; bus.lm = 1'b1; bus.prog = 1'b0; bus.a = 8'h24; bus.in = 8'h0F;
    #1;
    check_lit("pre_load", 8'h00);
    @(posedge clk);
    #1;
    check_lit("run_load", 8'h24);

    // Program-mode load, then stepping switches with one-edge latency.
    drive(1'b0, 1'b1, 1'b1, 8'h24, 8'h0F);
    check_lit("prog_load", 8'h0F);
    drive(1'b0, 1'b1, 1'b1, 8'h24, 8'h10);
    check_lit("prog_step10", 8'h10);
    drive(1'b0, 1'b1, 1'b1, 8'h24, 8'h11);
    check_lit("prog_step11", 8'h11);

    // Mode switch between edges while loading.
    drive(1'b0, 1'b1, 1'b1, 8'hAA, 8'h33);
    check_lit("switch_prog", 8'h33);
    drive(1'b0, 1'b1, 1'b0, 8'hAA, 8'h33);
    check_lit("switch_run", 8'hAA);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, ~i[0], 8'(8'h01 + i), 8'(8'hF0 - i));
      check_lit("hold_aa", 8'hAA);
    end

    // Boundary: full-width value passes unchanged, then reset beats load.
    drive(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    check_lit("full_ff", 8'hFF);
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    check_lit("reset_over_load", 8'h00);

    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_input_and_mar
`default_nettype wire

// File: doc/input_and_mar.md
Name: input_and_mar

Overview:
- Memory Address Register (MAR) with a program/run input selector for the SAP-2-mini CPU.
- In run mode, the MAR loads its address from the CPU W-bus (`a`). In program mode, it loads from the front-panel address switches (`in`).
- The registered output `out` drives the RAM address lines.

Parameters:
- WIDTH, 8, address/data width of `a`, `in` and `out`.
- RESET_VALUE, 0, value loaded into the MAR on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  synchronous, active-high reset.
- lm  input  1  load-MAR enable, active high.
- prog  input  1  source select: 1 = switches (`in`), 0 = bus (`a`).
- a  input  WIDTH  address from the W-bus (run mode).
- in  input  WIDTH  address from the front-panel switches (program mode).
- out  output  WIDTH  registered MAR contents, to the RAM address inputs.

Behaviour:
- Single WIDTH-bit register `mar`; `out` = `mar` directly. No combinational path from any input to `out`.
- Priority at each rising edge of `clk`:
  - clr=1: `mar` <= RESET_VALUE, regardless of lm, prog, a and in. Reset wins over load.
  - else lm=1, prog=1: `mar` <= `in`.
  - else lm=1, prog=0: `mar` <= `a`.
  - else (lm=0): `mar` holds its value.
- Latency: a value presented on `a` or `in` with lm=1 appears on `out` one edge later. Sample point is the rising edge.
- `prog`, `a` and `in` are don't-care while lm=0. Toggling them must not disturb `out`.
- Switching `prog` while lm=1 takes effect at the next edge. The selected source is the one `prog` indicates at that edge.
- Power-up value is undefined until the first clr edge. The bench must apply clr before checking.
- No arithmetic, no wrap-around. Full-width values pass unchanged, e.g. 8'hFF loads as 8'hFF.
- All inputs are synchronous to `clk`. No internal synchronizers.

Decomposition:
- No shared package required.
- WIDTH defaults to the CPU-wide address width constant, if the shared SAP-2-mini package defines one.
- Single module. The 2:1 select can be an inline conditional. No sub-module is needed.

Test Plan:
- Reset: clr=1 for one edge with lm=1, prog=1, in=8'h55 -> out=8'h00 after the edge. Reset priority confirmed.
- Hold: after reset, lm=0, prog toggling, a and in changing every cycle -> out stays 8'h00 for 4 edges.
- Run-mode load: lm=1, prog=0, a=8'h24, in=8'h0F -> out=8'h24 after the next edge. Before that edge, out still shows the old value.
- Program-mode load: lm=1, prog=1, in=8'h0F, a=8'h24 -> out=8'h0F after the edge. Then `in` steps 8'h10, 8'h11 on consecutive edges -> out follows with one-edge latency.
- Mode switch mid-load: lm=1, prog goes 1->0 between edges with a=8'hAA, in=8'h33 -> out=8'h33 at the first edge, 8'hAA at the second. Then lm=0 -> out holds 8'hAA while a and in change.
- Boundary: lm=1, prog=0, a=8'hFF -> out=8'hFF. Next edge clr=1 with lm=1 -> out=8'h00.
